// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream program loader into 32-bit instruction memory
module instr_mem_loader #(
   parameter int DEPTH = 32
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        start,
   input  logic [5:0]  numWords,
   input  logic [7:0]  byteData,
   input  logic        byteValid,
   output logic        byteReady,
   output logic        memWrEn,
   output logic [31:0] memWrAddr,
   output logic [31:0] memWrData,
   output logic        cpuHold,
   output logic        done,
   output logic [5:0]  wordCount
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   localparam logic [5:0] DEPTH_W = 6'(DEPTH);

   state_t      r_state;
   state_t      w_next_state;
   logic        r_byte_ready;
   logic        r_mem_wr_en;
   logic        r_cpu_hold;
   logic        r_done;
   logic [31:0] r_mem_wr_addr;
   logic [31:0] r_mem_wr_data;
   logic [5:0]  r_word_count;
   logic [5:0]  r_target;
   logic [1:0]  r_byte_idx;
   logic [23:0] r_assy;

   logic        w_accept;
   logic        w_last;
   logic [5:0]  w_target_in;

   // A byte moves only on a valid/ready handshake while loading
   assign w_accept    = (r_state == LOAD) && r_byte_ready && byteValid;
   // Clamp the request so the address can never run past the memory
   assign w_target_in = (numWords > DEPTH_W) ? DEPTH_W : numWords;
   // Widened compare so a target of 63 cannot wrap
   assign w_last      = (({1'b0, r_word_count} + 7'd1) == {1'b0, r_target});

   // Next-state decode
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:  if (start) w_next_state = (w_target_in == 6'd0) ? DONE : LOAD;
         LOAD:  if (w_accept && (r_byte_idx == 2'd3)) w_next_state = WRITE;
         WRITE: w_next_state = w_last ? DONE : LOAD;
         DONE:  w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State register and state-decoded outputs, registered so they line up with the state
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_state      <= IDLE;
         r_byte_ready <= 1'b0;
         r_mem_wr_en  <= 1'b0;
         r_cpu_hold   <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_byte_ready <= (w_next_state == LOAD);
         r_mem_wr_en  <= (w_next_state == WRITE);
         r_cpu_hold   <= (w_next_state != IDLE);
         r_done       <= (w_next_state == DONE);
      end
   end

   // Word assembly, write address/data capture and word counting
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_mem_wr_addr <= 32'd0;
         r_mem_wr_data <= 32'd0;
         r_word_count  <= 6'd0;
         r_target      <= 6'd0;
         r_byte_idx    <= 2'd0;
         r_assy        <= 24'd0;
      end else begin
         if ((r_state == IDLE) && start) begin
            r_target     <= w_target_in;
            r_word_count <= 6'd0;
            r_byte_idx   <= 2'd0;
         end
         if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            unique case (r_byte_idx)
               2'd0: r_assy[7:0]   <= byteData;
               2'd1: r_assy[15:8]  <= byteData;
               2'd2: r_assy[23:16] <= byteData;
               default: begin
                  r_mem_wr_data <= {byteData, r_assy};
                  r_mem_wr_addr <= {24'd0, r_word_count, 2'b00};
               end
            endcase
         end
         if (r_state == WRITE) begin
            r_word_count <= r_word_count + 6'd1;
         end
      end
   end

   assign byteReady = r_byte_ready;
   assign memWrEn   = r_mem_wr_en;
   assign memWrAddr = r_mem_wr_addr;
   assign memWrData = r_mem_wr_data;
   assign cpuHold   = r_cpu_hold;
   assign done      = r_done;
   assign wordCount = r_word_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader
module tb_instr_mem_loader;

   logic        CLK;
   logic        RESETn;
   logic        start;
   logic [5:0]  numWords;
   logic [7:0]  byteData;
   logic        byteValid;
   logic        byteReady;
   logic        memWrEn;
   logic [31:0] memWrAddr;
   logic [31:0] memWrData;
   logic        cpuHold;
   logic        done;
   logic [5:0]  wordCount;

   int checks   = 0;
   int failures = 0;
   int n_writes = 0;
   logic [31:0] last_addr = 32'd0;
   logic [63:0] exp_q[$];

   instr_mem_loader #(.DEPTH(32)) dut (
      .CLK(CLK), .RESETn(RESETn), .start(start), .numWords(numWords),
      .byteData(byteData), .byteValid(byteValid), .byteReady(byteReady),
      .memWrEn(memWrEn), .memWrAddr(memWrAddr), .memWrData(memWrData),
      .cpuHold(cpuHold), .done(done), .wordCount(wordCount)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Write monitor: every strobe must match the next expected {addr,data}
   always @(negedge CLK) begin
      if (RESETn && memWrEn) begin
         logic [63:0] exp_w;
         n_writes++;
         last_addr = memWrAddr;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%h data=%h", memWrAddr, memWrData);
         end else begin
            exp_w = exp_q.pop_front();
            if ({memWrAddr, memWrData} !== exp_w) begin
               failures++;
               $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                        memWrAddr, memWrData, exp_w[63:32], exp_w[31:0]);
            end
         end
      end
   end

   task automatic start_load(input logic [5:0] n);
      @(posedge CLK); #1;
      start = 1'b1; numWords = n;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 0;
      byteData = b; byteValid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (byteReady) begin
            @(posedge CLK); #1;
            ok = 1;
            break;
         end
      end
      byteValid = 1'b0;
      if (!ok) begin
         checks++; failures++;
         $display("FAIL byte_timeout byte=%h byteReady never rose", b);
      end
   endtask

   task automatic wait_done(output bit seen);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (done) begin
            seen = 1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #3;
      checks++;
      if ({byteReady, memWrEn, cpuHold, done} !== 4'b0 || memWrAddr !== 32'd0 ||
          memWrData !== 32'd0 || wordCount !== 6'd0) begin
         failures++;
         $display("FAIL reset_state got rdy=%b we=%b hold=%b done=%b addr=%h data=%h wc=%0d expected all zero",
                  byteReady, memWrEn, cpuHold, done, memWrAddr, memWrData, wordCount);
      end
      @(negedge CLK); RESETn = 1'b1;
   endtask

   task automatic test_basic;
      bit seen;
      int w0;
      logic [7:0] bytes[8];
      bytes = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
      w0 = n_writes;
      exp_q.push_back({32'h0, 32'h00100013});
      exp_q.push_back({32'h4, 32'h00200093});
      start_load(6'd2);
      checks++;
      if (cpuHold !== 1'b1 || byteReady !== 1'b1) begin
         failures++;
         $display("FAIL basic_load_entry got hold=%b rdy=%b expected 1 1", cpuHold, byteReady);
      end
      for (int i = 0; i < 8; i++) send_byte(bytes[i]);
      wait_done(seen);
      checks++;
      if (!seen || cpuHold !== 1'b1) begin
         failures++;
         $display("FAIL basic_done got seen=%b hold=%b expected 1 1", seen, cpuHold);
      end
      @(negedge CLK);
      checks++;
      if (done !== 1'b0 || cpuHold !== 1'b0) begin
         failures++;
         $display("FAIL basic_after_done got done=%b hold=%b expected 0 0", done, cpuHold);
      end
      checks++;
      if (n_writes - w0 != 2 || wordCount !== 6'd2) begin
         failures++;
         $display("FAIL basic_count got writes=%0d wc=%0d expected 2 2", n_writes - w0, wordCount);
      end
   endtask

   task automatic test_zero;
      int w0;
      w0 = n_writes;
      start_load(6'd0);
      @(negedge CLK);
      checks++;
      if (done !== 1'b1 || wordCount !== 6'd0) begin
         failures++;
         $display("FAIL zero_done got done=%b wc=%0d expected 1 0", done, wordCount);
      end
      repeat (4) @(negedge CLK);
      checks++;
      if (n_writes != w0 || cpuHold !== 1'b0) begin
         failures++;
         $display("FAIL zero_nowrite got writes=%0d hold=%b expected 0 0", n_writes - w0, cpuHold);
      end
   endtask

   task automatic test_clamp;
      int w0;
      int rdy_seen;
      bit seen;
      logic [7:0] b;
      w0 = n_writes;
      rdy_seen = 0;
      for (int w = 0; w < 32; w++) begin
         logic [7:0] b0;
         b0 = 8'(4 * w);
         exp_q.push_back({32'(4 * w), b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
      end
      start_load(6'd40);
      for (int i = 0; i < 128; i++) begin
         b = 8'(i);
         send_byte(b);
      end
      wait_done(seen);
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL clamp_done got seen=0 expected 1");
      end
      for (int i = 128; i < 160; i++) begin
         byteData = 8'(i); byteValid = 1'b1;
         @(negedge CLK);
         if (byteReady) rdy_seen++;
         @(posedge CLK); #1;
      end
      byteValid = 1'b0;
      checks++;
      if (rdy_seen != 0) begin
         failures++;
         $display("FAIL clamp_ready_after_128 got %0d ready cycles expected 0", rdy_seen);
      end
      checks++;
      if (n_writes - w0 != 32 || last_addr !== 32'h7C || wordCount !== 6'd32) begin
         failures++;
         $display("FAIL clamp_totals got writes=%0d last=%h wc=%0d expected 32 7c 32",
                  n_writes - w0, last_addr, wordCount);
      end
   endtask

   task automatic test_gaps;
      int w0;
      bit seen;
      logic [7:0] bytes[4];
      bytes = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      for (int pass = 0; pass < 2; pass++) begin
         w0 = n_writes;
         exp_q.push_back({32'h0, 32'hA1B2C3D4});
         start_load(6'd1);
         for (int i = 0; i < 4; i++) begin
            if (pass == 1) begin
               int g;
               g = $urandom_range(1, 6);
               byteValid = 1'b0;
               for (int k = 0; k < g; k++) begin
                  byteData = 8'($urandom);
                  @(posedge CLK);
               end
               #1;
            end
            send_byte(bytes[i]);
         end
         wait_done(seen);
         @(negedge CLK);
         checks++;
         if (!seen || n_writes - w0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL gaps_pass%0d got seen=%b writes=%0d pending=%0d expected 1 1 0",
                     pass, seen, n_writes - w0, exp_q.size());
         end
      end
   endtask

   task automatic test_reset_midload;
      int w0;
      bit seen;
      w0 = n_writes;
      start_load(6'd3);
      send_byte(8'h11);
      send_byte(8'h22);
      #2; RESETn = 1'b0; #1;
      checks++;
      if ({byteReady, memWrEn, cpuHold, done} !== 4'b0 || memWrAddr !== 32'd0 ||
          memWrData !== 32'd0 || wordCount !== 6'd0) begin
         failures++;
         $display("FAIL midload_reset got rdy=%b we=%b hold=%b done=%b addr=%h data=%h wc=%0d expected all zero",
                  byteReady, memWrEn, cpuHold, done, memWrAddr, memWrData, wordCount);
      end
      @(negedge CLK); RESETn = 1'b1;
      byteData = 8'h33; byteValid = 1'b1;
      repeat (4) @(negedge CLK);
      byteValid = 1'b0;
      checks++;
      if (cpuHold !== 1'b0 || byteReady !== 1'b0 || n_writes != w0) begin
         failures++;
         $display("FAIL midload_idle got hold=%b rdy=%b writes=%0d expected 0 0 0",
                  cpuHold, byteReady, n_writes - w0);
      end
      exp_q.push_back({32'h0, 32'hDDCCBBAA});
      start_load(6'd1);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      wait_done(seen);
      checks++;
      if (!seen || n_writes - w0 != 1 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL midload_reload got seen=%b writes=%0d pending=%0d expected 1 1 0",
                  seen, n_writes - w0, exp_q.size());
      end
   endtask

   task automatic test_start_in_load;
      int w0;
      bit seen;
      w0 = n_writes;
      exp_q.push_back({32'h0, 32'h44332211});
      exp_q.push_back({32'h4, 32'h88776655});
      start_load(6'd2);
      send_byte(8'h11); send_byte(8'h22);
      start_load(6'd1);
      checks++;
      if (byteReady !== 1'b1 || cpuHold !== 1'b1 || wordCount !== 6'd0) begin
         failures++;
         $display("FAIL start_in_load_state got rdy=%b hold=%b wc=%0d expected 1 1 0",
                  byteReady, cpuHold, wordCount);
      end
      send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
      wait_done(seen);
      checks++;
      if (!seen || n_writes - w0 != 2 || wordCount !== 6'd2 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL start_in_load_result got seen=%b writes=%0d wc=%0d pending=%0d expected 1 2 2 0",
                  seen, n_writes - w0, wordCount, exp_q.size());
      end
   endtask

   initial begin
      RESETn = 1'b0; start = 1'b0; numWords = 6'd0;
      byteData = 8'd0; byteValid = 1'b0;
      test_reset;
      test_basic;
      test_zero;
      test_clamp;
      test_gaps;
      test_reset_midload;
      test_start_in_load;
      repeat (3) @(negedge CLK);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got %0d pending writes expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, the number of 32-bit instruction words the target memory holds.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port RESETn, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, which requests a program load.
REQ-005 The block SHALL have port numWords, input, 6, the number of words to load, sampled when start is accepted.
REQ-006 The block SHALL have port byteData, input, 8, the incoming program byte.
REQ-007 The block SHALL have port byteValid, input, 1, indicating that byteData is valid.
REQ-008 The block SHALL have port byteReady, output, 1, indicating that the block accepts a byte this cycle.
REQ-009 The block SHALL have port memWrEn, output, 1, the instruction-memory write strobe.
REQ-010 The block SHALL have port memWrAddr, output, 32, the byte address of the word being written; bits [1:0] are always 0.
REQ-011 The block SHALL have port memWrData, output, 32, the assembled instruction word.
REQ-012 The block SHALL have port cpuHold, output, 1, which stalls the CPU and PC while loading.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse marking load completion.
REQ-014 The block SHALL have port wordCount, output, 6, the number of words written so far in the current load.

Function
REQ-015 The block SHALL implement the states IDLE, LOAD, WRITE and DONE, all outputs registered.
REQ-016 In IDLE, start=1 SHALL latch target = min(numWords, DEPTH), clear wordCount and the byte index, and move to LOAD; if target is 0, it SHALL move directly to DONE instead.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 byteReady SHALL be 1 only in LOAD.
REQ-019 A byte SHALL be accepted only at a rising edge where byteValid=1 and byteReady=1; byteValid without byteReady SHALL have no effect.
REQ-020 Bytes SHALL assemble little-endian: the k-th accepted byte of a word (k = 0..3) fills bits [8k+7:8k].
REQ-021 Acceptance of the 4th byte SHALL move the block to WRITE; in the next cycle memWrEn=1 for exactly one cycle, with memWrData equal to the assembled word and memWrAddr = {wordCount, 2'b00} zero-extended.
REQ-022 On leaving WRITE, wordCount SHALL increment; the block SHALL then go to DONE if wordCount+1 equals target, and otherwise return to LOAD.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle, after which the block returns to IDLE.
REQ-024 cpuHold SHALL be 1 in LOAD, WRITE and DONE, and 0 in IDLE.
REQ-025 wordCount SHALL hold its final value in IDLE until the next accepted start.
REQ-026 memWrAddr SHALL never exceed (DEPTH-1)*4, because target is clamped to DEPTH.
REQ-027 Gaps of any length between bytes (byteValid=0) SHALL be tolerated without timeout, with partial-word state retained.
REQ-028 Outside WRITE, memWrEn SHALL be 0 and memWrAddr and memWrData SHALL hold their last values.

Reset
REQ-029 RESETn=0 SHALL immediately, without waiting for a clock edge, force state to IDLE and set byteReady, memWrEn, cpuHold and done to 0, and memWrAddr, memWrData and wordCount to 0.
REQ-030 Reset asserted mid-load SHALL discard any partial word, and the block SHALL remain in IDLE after RESETn rises until a new start arrives.

Verification
REQ-031 The bench SHALL drive start with numWords=2 and bytes 13,00,10,00,93,00,20,00 (hex), and check two writes: addr 0 data 0x00100013, then addr 4 data 0x00200093, followed by a done pulse and cpuHold falling one cycle after done.
REQ-032 The bench SHALL drive start with numWords=0 and check: no memWrEn, done pulses one cycle after start is accepted, and wordCount=0.
REQ-033 The bench SHALL drive start with numWords=40 and 160 bytes, and check: exactly 32 writes, last addr 0x7C, byteReady=0 after the 128th byte, and wordCount=32.
REQ-034 The bench SHALL randomly deassert byteValid during a 1-word load, and check that the data is identical to the gap-free case and memWrEn pulses once.
REQ-035 The bench SHALL pulse RESETn low after 2 bytes of a load, and check that outputs clear immediately, no write occurs, and a subsequent full load starts at addr 0.
REQ-036 The bench SHALL assert start while in LOAD, and check that it has no effect on target, wordCount or state.
